// File: rtl/pe_mv_con_if.sv
// Bundle of pe_mv_con's pass-control, memory-read and result signals.
// Latency: none; wires only.
// Backpressure: none; start is level-sampled, memory answers one cycle after rdaddr.
interface pe_mv_con_if #(
    parameter int L_RAM_SIZE = 4,
    parameter int NUM_PE     = 4,
    parameter int DATA_W     = 32,
    parameter int ACC_W      = 64,
    parameter int ADDR_W     = $clog2((NUM_PE + 1) * (2 ** L_RAM_SIZE))
);
    logic                    start;
    logic                    acc_keep;
    logic [DATA_W-1:0]       rddata;
    logic [ADDR_W-1:0]       rdaddr;
    logic                    busy;
    logic                    done;
    logic                    res_valid;
    logic [NUM_PE*ACC_W-1:0] result;

    // Host/memory side: requests passes, returns read data, observes results.
    modport master (
        output start,
        output acc_keep,
        output rddata,
        input  rdaddr,
        input  busy,
        input  done,
        input  res_valid,
        input  result
    );

    // Controller side.
    modport slave (
        input  start,
        input  acc_keep,
        input  rddata,
        output rdaddr,
        output busy,
        output done,
        output res_valid,
        output result
    );
endinterface

// File: rtl/pe_mv_con.sv
// Multi-lane PE controller: loads vector B plus NUM_PE rows, then runs NUM_PE signed MAC lanes.
// Latency: done pulses W+N+1 edges after start is accepted (W=(NUM_PE+1)*N words loaded).
// Backpressure: start is ignored while busy; no queuing, memory must answer in exactly one cycle.
module pe_mv_con #(
    parameter int L_RAM_SIZE = 4,
    parameter int NUM_PE     = 4,
    parameter int DATA_W     = 32,
    parameter int ACC_W      = 64,
    parameter int ADDR_W     = $clog2((NUM_PE + 1) * (2 ** L_RAM_SIZE))
) (
    input  logic          aclk,
    input  logic          areset,
    pe_mv_con_if.slave    bus
);
    localparam int N  = 2 ** L_RAM_SIZE;
    localparam int W  = (NUM_PE + 1) * N;
    localparam int RW = ADDR_W - L_RAM_SIZE;
    localparam int PW = 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state;
    logic [ADDR_W-1:0]       rdaddr_q;
    logic                    iss_vld;      // rdaddr_q holds an address still to be issued
    logic                    cap_vld;      // rddata this cycle belongs to cap_addr
    logic [ADDR_W-1:0]       cap_addr;
    logic [L_RAM_SIZE-1:0]   kcnt;
    logic                    busy_q;
    logic                    done_q;
    logic                    res_valid_q;

    logic signed [ACC_W-1:0] acc      [NUM_PE];
    logic [DATA_W-1:0]       vec_buf  [N];
    logic [DATA_W-1:0]       row_buf  [NUM_PE][N];

    logic signed [PW-1:0]    prod     [NUM_PE];
    logic signed [ACC_W-1:0] prod_ext [NUM_PE];

    logic [L_RAM_SIZE-1:0]   cap_k;
    logic [RW-1:0]           cap_blk;

    // Words of the same block share low address bits, so the block number is the upper field.
    assign cap_k   = cap_addr[L_RAM_SIZE-1:0];
    assign cap_blk = cap_addr[ADDR_W-1:L_RAM_SIZE];

    // Per-lane full-width signed product of element kcnt, fitted to the accumulator width.
    always_comb begin
        for (int i = 0; i < NUM_PE; i++) begin
            prod[i]     = PW'($signed(row_buf[i][kcnt])) * PW'($signed(vec_buf[kcnt]));
            prod_ext[i] = ACC_W'(prod[i]);
        end
    end

    // Operand buffers: block 0 is the shared vector, block r+1 is lane r's row.
    always_ff @(posedge aclk) begin
        if (cap_vld) begin
            if (cap_blk == '0) begin
                vec_buf[cap_k] <= bus.rddata;
            end
            for (int r = 0; r < NUM_PE; r++) begin
                if (cap_blk == RW'(r + 1)) begin
                    row_buf[r][cap_k] <= bus.rddata;
                end
            end
        end
    end

    // Pass sequencer with registered outputs and the lane accumulators.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state       <= IDLE;
            rdaddr_q    <= '0;
            iss_vld     <= 1'b0;
            cap_vld     <= 1'b0;
            cap_addr    <= '0;
            kcnt        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            for (int i = 0; i < NUM_PE; i++) begin
                acc[i] <= '0;
            end
        end else begin
            // Read data trails the issued address by one cycle.
            cap_vld  <= iss_vld;
            cap_addr <= rdaddr_q;
            done_q   <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state       <= LOAD;
                        busy_q      <= 1'b1;
                        res_valid_q <= 1'b0;
                        iss_vld     <= 1'b1;
                        rdaddr_q    <= '0;
                        kcnt        <= '0;
                        if (!bus.acc_keep) begin
                            for (int i = 0; i < NUM_PE; i++) begin
                                acc[i] <= '0;
                            end
                        end
                    end
                end

                LOAD: begin
                    if (iss_vld) begin
                        if (rdaddr_q == ADDR_W'(W - 1)) begin
                            iss_vld <= 1'b0;
                        end else begin
                            rdaddr_q <= rdaddr_q + 1'b1;
                        end
                    end
                    // Leave once the final word has landed in its buffer.
                    if (cap_vld && (cap_addr == ADDR_W'(W - 1))) begin
                        state <= CALC;
                    end
                end

                CALC: begin
                    for (int i = 0; i < NUM_PE; i++) begin
                        acc[i] <= acc[i] + prod_ext[i];
                    end
                    kcnt <= kcnt + 1'b1;
                    if (&kcnt) begin
                        state       <= DONE;
                        done_q      <= 1'b1;
                        res_valid_q <= 1'b1;
                    end
                end

                DONE: begin
                    state    <= IDLE;
                    busy_q   <= 1'b0;
                    rdaddr_q <= '0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.rdaddr    = rdaddr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.res_valid = res_valid_q;

    // Result lanes come straight off the accumulators; they only move during CALC or at accept.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PE; gi++) begin : g_res
            assign bus.result[gi*ACC_W +: ACC_W] = acc[gi];
        end
    endgenerate

endmodule
